// File: rtl/fp_mul_iter.sv
// ---------------------------------------------------------------------------
// fp_mul_iter
// Iterative floating-point multiplier (IEEE-754 binary32 with the default
// parameters). The significand product is formed by shift-and-add, one
// partial product per clock, so every operation takes a fixed 26 cycles from
// acceptance to result. It uses the same arg_vld/busy/res_vld handshake as
// the iterative divider.
//
// Optional feature macro: FP_MUL_RNE_EN
//   defined   : round-to-nearest-even on the normalised product
//   undefined : truncate (round toward zero); no guard/sticky logic is built
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset; aborts an operation in flight
//   arg_vld  in   operands valid; only accepted while busy is low
//   busy     out  operation in progress
//   res_vld  out  one-cycle pulse when c carries a new product
//   a, b     in   operands
//   c        out  product; holds until the next result
//
// Subnormal operands are treated as zero and tiny results flush to signed
// zero. Specials (NaN, inf, zero) are decoded when the operands are accepted
// and replace the arithmetic result at the end, keeping latency constant.
// ---------------------------------------------------------------------------
module fp_mul_iter #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arg_vld,
    output logic                    busy,
    output logic                    res_vld,
    input  logic [EXP_W+MANT_W:0]   a,
    input  logic [EXP_W+MANT_W:0]   b,
    output logic [EXP_W+MANT_W:0]   c
);

    localparam int WW      = 1 + EXP_W + MANT_W;   // word width
    localparam int SW      = MANT_W + 1;           // significand width
    localparam int PW      = 2 * SW;               // product width
    localparam int EW      = EXP_W + 2;            // signed exponent width
    localparam int CW      = $clog2(SW);
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    localparam logic signed [EW-1:0] EXP_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_TOP  = EW'(EXP_MAX);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
    localparam logic [CW-1:0]        CNT_LAST = CW'(SW - 1);
    localparam logic [WW-1:0]        QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   accept_s;

    logic [PW-1:0]          mcand_r;
    logic [SW-1:0]          mplier_r;
    logic [PW-1:0]          acc_r;
    logic [CW-1:0]          cnt_r;
    logic signed [EW-1:0]   exp_r;
    logic                   sign_r;
    logic                   special_r;
    logic [WW-1:0]          spec_val_r;
    logic                   busy_r;
    logic                   res_vld_r;
    logic [WW-1:0]          c_r;

    // Operand field decode
    logic [EXP_W-1:0]       a_exp_s, b_exp_s;
    logic [MANT_W-1:0]      a_frac_s, b_frac_s;
    logic                   a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic                   sign_s;
    logic signed [EW-1:0]   exp_sum_s;
    logic                   spec_hit_s;
    logic [WW-1:0]          spec_val_s;

    assign a_exp_s   = a[WW-2 -: EXP_W];
    assign b_exp_s   = b[WW-2 -: EXP_W];
    assign a_frac_s  = a[MANT_W-1:0];
    assign b_frac_s  = b[MANT_W-1:0];
    assign a_zero_s  = (a_exp_s == {EXP_W{1'b0}});
    assign b_zero_s  = (b_exp_s == {EXP_W{1'b0}});
    assign a_inf_s   = (a_exp_s == {EXP_W{1'b1}}) && (a_frac_s == {MANT_W{1'b0}});
    assign b_inf_s   = (b_exp_s == {EXP_W{1'b1}}) && (b_frac_s == {MANT_W{1'b0}});
    assign a_nan_s   = (a_exp_s == {EXP_W{1'b1}}) && (a_frac_s != {MANT_W{1'b0}});
    assign b_nan_s   = (b_exp_s == {EXP_W{1'b1}}) && (b_frac_s != {MANT_W{1'b0}});
    assign sign_s    = a[WW-1] ^ b[WW-1];
    assign exp_sum_s = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s}) - EXP_BIAS;

    // Special-operand priority: NaN, inf*zero, inf, zero
    always_comb begin
        spec_hit_s = 1'b0;
        spec_val_s = {WW{1'b0}};
        if (a_nan_s || b_nan_s) begin
            spec_hit_s = 1'b1;
            spec_val_s = QNAN;
        end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            spec_hit_s = 1'b1;
            spec_val_s = QNAN;
        end else if (a_inf_s || b_inf_s) begin
            spec_hit_s = 1'b1;
            spec_val_s = {sign_s, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (a_zero_s || b_zero_s) begin
            spec_hit_s = 1'b1;
            spec_val_s = {sign_s, {(WW-1){1'b0}}};
        end else begin
            spec_hit_s = 1'b0;
            spec_val_s = {WW{1'b0}};
        end
    end

    // Normalisation: a product in [2,4) has its top bit set and bumps the exponent
    logic [PW-1:0]          prod_norm_s;
    logic signed [EW-1:0]   exp_n_s;
    logic [MANT_W-1:0]      frac_t_s;
    logic [MANT_W-1:0]      frac_f_s;
    logic signed [EW-1:0]   exp_f_s;

    assign prod_norm_s = acc_r[PW-1] ? acc_r : {acc_r[PW-2:0], 1'b0};
    assign exp_n_s     = exp_r + $signed({{(EW-1){1'b0}}, acc_r[PW-1]});
    assign frac_t_s    = prod_norm_s[PW-2 -: MANT_W];

`ifdef FP_MUL_RNE_EN
    logic                   guard_s;
    logic                   sticky_s;
    logic                   rnd_inc_s;
    logic [MANT_W:0]        frac_sum_s;

    assign guard_s    = prod_norm_s[PW-2-MANT_W];
    assign sticky_s   = |prod_norm_s[PW-3-MANT_W:0];
    assign rnd_inc_s  = guard_s && (sticky_s || frac_t_s[0]);
    assign frac_sum_s = {1'b0, frac_t_s} + {{MANT_W{1'b0}}, rnd_inc_s};
    // A carry out of the fraction leaves it all-zero and moves the exponent up
    assign frac_f_s   = frac_sum_s[MANT_W-1:0];
    assign exp_f_s    = exp_n_s + $signed({{(EW-1){1'b0}}, frac_sum_s[MANT_W]});
`else
    logic                   unused_low_s;

    assign unused_low_s = ^prod_norm_s[PW-2-MANT_W:0];
    assign frac_f_s     = frac_t_s;
    assign exp_f_s      = exp_n_s;
`endif

    // Final result selection: specials, overflow to inf, underflow to zero
    logic [WW-1:0]          res_s;

    always_comb begin
        res_s = {WW{1'b0}};
        if (special_r) begin
            res_s = spec_val_r;
        end else if (exp_f_s >= EXP_TOP) begin
            res_s = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (exp_f_s <= EXP_ZERO) begin
            res_s = {sign_r, {(WW-1){1'b0}}};
        end else begin
            res_s = {sign_r, exp_f_s[EXP_W-1:0], frac_f_s};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and operand acceptance
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (arg_vld) begin
                    accept_s    = 1'b1;
                    state_nxt_s = MUL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = NORM;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            NORM:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-and-add iterations, result register
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r    <= {PW{1'b0}};
            mplier_r   <= {SW{1'b0}};
            acc_r      <= {PW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            exp_r      <= EXP_ZERO;
            sign_r     <= 1'b0;
            special_r  <= 1'b0;
            spec_val_r <= {WW{1'b0}};
            busy_r     <= 1'b0;
            res_vld_r  <= 1'b0;
            c_r        <= {WW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mcand_r    <= {{SW{1'b0}}, ~a_zero_s, a_frac_s};
                        mplier_r   <= {~b_zero_s, b_frac_s};
                        acc_r      <= {PW{1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        exp_r      <= exp_sum_s;
                        sign_r     <= sign_s;
                        special_r  <= spec_hit_s;
                        spec_val_r <= spec_val_s;
                    end
                end
                MUL: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mplier_r <= {1'b0, mplier_r[SW-1:1]};
                    mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                    cnt_r    <= cnt_r + CW'(1);
                end
                NORM: begin
                    c_r <= res_s;
                end
                default: begin
                    c_r <= c_r;
                end
            endcase
            busy_r    <= (state_nxt_s != IDLE);
            res_vld_r <= (state_r == NORM);
        end
    end

    assign busy    = busy_r;
    assign res_vld = res_vld_r;
    assign c       = c_r;

endmodule
